// File: rtl/clic_irq_dispatch.sv
// clic_irq_dispatch: sending end of the CLIC core interrupt interface.
// A multi-cycle sweep finds the eligible source with the largest
// {priv, level, id} key. The winner is offered to the core over a
// valid/ready handshake. The offer is withdrawn through a kill
// request/acknowledge pair when a better candidate shows up, or when the
// offered source stops being eligible.
module clic_irq_dispatch #(
    parameter int NumSrc      = 256,
    parameter int SrcPerCycle = 16,
    parameter int LevelWidth  = 8,
    localparam int IdWidth    = $clog2(NumSrc)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic [NumSrc-1:0]            ip_i,
    input  logic [NumSrc-1:0]            ie_i,
    input  logic [NumSrc*LevelWidth-1:0] level_i,
    input  logic [2*NumSrc-1:0]          priv_i,
    input  logic [NumSrc-1:0]            shv_i,
    input  logic [NumSrc-1:0]            edge_i,
    input  logic [LevelWidth-1:0]        thresh_i,
    output logic                         irq_valid_o,
    input  logic                         irq_ready_i,
    output logic [IdWidth-1:0]           irq_id_o,
    output logic [LevelWidth-1:0]        irq_level_o,
    output logic [1:0]                   irq_priv_o,
    output logic                         irq_shv_o,
    output logic                         irq_kill_req_o,
    input  logic                         irq_kill_ack_i,
    output logic                         ip_clr_valid_o,
    output logic [IdWidth-1:0]           ip_clr_id_o
);

    localparam int NumGrp   = NumSrc / SrcPerCycle;
    localparam int GrpWidth = (NumGrp > 1) ? $clog2(NumGrp) : 1;
    localparam int KeyWidth = 2 + LevelWidth + IdWidth;
    localparam logic [GrpWidth-1:0] LastGrp = GrpWidth'(NumGrp - 1);

    typedef enum logic [1:0] {SCAN, OFFER, KILL} state_t;

    state_t                 state, state_next;
    logic [GrpWidth-1:0]    grp;
    logic                   best_valid, best_hit;
    logic [KeyWidth-1:0]    best_key;
    logic                   grp_valid, grp_hit;
    logic [KeyWidth-1:0]    grp_key;
    logic                   sweep_valid, sweep_hit;
    logic [KeyWidth-1:0]    sweep_key;
    logic [IdWidth-1:0]     lane_id;
    logic                   lane_elig;
    logic [KeyWidth-1:0]    lane_key;
    logic [IdWidth-1:0]     offer_id;
    logic [LevelWidth-1:0]  offer_level;
    logic [1:0]             offer_priv;
    logic                   offer_shv;
    logic [KeyWidth-1:0]    offer_key;
    logic                   clr_valid;
    logic [IdWidth-1:0]     clr_id;
    logic                   last_grp, kill_cond;
    logic                   load_offer, accept, restart;

    // Per-source views of the flattened level and privilege buses.
    logic [LevelWidth-1:0]  level [NumSrc];
    logic [1:0]             priv  [NumSrc];

    for (genvar k = 0; k < NumSrc; k++) begin : g_unpack
        assign level[k] = level_i[k*LevelWidth +: LevelWidth];
        assign priv[k]  = priv_i[2*k +: 2];
    end

    assign last_grp  = (grp == LastGrp);
    assign offer_key = {offer_priv, offer_level, offer_id};

    // Best eligible source of the current group. The id is part of the key, so ties cannot occur.
    always_comb begin
        // NOTE: every variable gets a value before the loop; a path that skips an assignment would infer a latch.
        grp_valid = 1'b0;
        grp_key   = '0;
        grp_hit   = 1'b0;
        lane_id   = '0;
        lane_elig = 1'b0;
        lane_key  = '0;
        for (int j = 0; j < SrcPerCycle; j++) begin
            lane_id   = IdWidth'(int'(grp) * SrcPerCycle + j);
            lane_elig = enable_i & ip_i[lane_id] & ie_i[lane_id] & (level[lane_id] > thresh_i);
            lane_key  = {priv[lane_id], level[lane_id], lane_id};
            if (lane_elig && (!grp_valid || lane_key > grp_key)) begin
                grp_valid = 1'b1;
                grp_key   = lane_key;
            end
            if (lane_elig && lane_id == offer_id) begin
                grp_hit = 1'b1;
            end
        end
    end

    // Fold the group winner into the running sweep result. Group 0 starts a fresh sweep.
    always_comb begin
        if (grp == '0) begin
            sweep_valid = grp_valid;
            sweep_hit   = grp_hit;
            sweep_key   = grp_key;
        end else begin
            sweep_valid = best_valid | grp_valid;
            sweep_hit   = best_hit | grp_hit;
            if (grp_valid && (!best_valid || grp_key > best_key)) begin
                sweep_key = grp_key;
            end else begin
                sweep_key = best_key;
            end
        end
    end

    // Withdraw when the finished sweep beats the offer or no longer sees the offered id as eligible.
    assign kill_cond = last_grp && ((sweep_valid && sweep_key > offer_key) || !sweep_hit);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Acceptance takes priority over both kill paths.
    always_comb begin
        state_next = state;
        load_offer = 1'b0;
        accept     = 1'b0;
        restart    = 1'b0;
        unique case (state)
            SCAN: begin
                if (last_grp && sweep_valid && !clr_valid) begin
                    state_next = OFFER;
                    load_offer = 1'b1;
                end
            end
            OFFER: begin
                if (irq_ready_i) begin
                    state_next = SCAN;
                    accept     = 1'b1;
                    restart    = 1'b1;
                end else if (kill_cond) begin
                    state_next = KILL;
                end
            end
            KILL: begin
                if (irq_ready_i) begin
                    state_next = SCAN;
                    accept     = 1'b1;
                    restart    = 1'b1;
                end else if (irq_kill_ack_i) begin
                    state_next = SCAN;
                    restart    = 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // Group counter and running best candidate. Both restart after every closed offer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            grp        <= '0;
            best_valid <= 1'b0;
            best_hit   <= 1'b0;
            best_key   <= '0;
        end else begin
            // NOTE: registered state always uses nonblocking assignments, so reads in the same edge see old values.
            best_valid <= sweep_valid;
            best_hit   <= sweep_hit;
            best_key   <= sweep_key;
            if (restart || last_grp) begin
                grp <= '0;
            end else begin
                grp <= grp + GrpWidth'(1);
            end
        end
    end

    // Offer payload and the pending-clear pulse for accepted edge-triggered sources.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            offer_id    <= '0;
            offer_level <= '0;
            offer_priv  <= '0;
            offer_shv   <= 1'b0;
            clr_valid   <= 1'b0;
            clr_id      <= '0;
        end else begin
            if (load_offer) begin
                offer_id    <= sweep_key[IdWidth-1:0];
                offer_level <= sweep_key[IdWidth +: LevelWidth];
                offer_priv  <= sweep_key[KeyWidth-1 -: 2];
                offer_shv   <= shv_i[sweep_key[IdWidth-1:0]];
            end
            clr_valid <= accept & edge_i[offer_id];
            if (accept) begin
                clr_id <= offer_id;
            end
        end
    end

    assign irq_valid_o    = (state != SCAN);
    assign irq_kill_req_o = (state == KILL);
    assign irq_id_o       = offer_id;
    assign irq_level_o    = offer_level;
    assign irq_priv_o     = offer_priv;
    assign irq_shv_o      = offer_shv;
    assign ip_clr_valid_o = clr_valid;
    assign ip_clr_id_o    = clr_id;

endmodule

// File: tb/tb_clic_irq_dispatch.sv
// Self-checking bench for clic_irq_dispatch: directed scenarios plus randomized
// source sets, compared against a whole-array arbitration model.
module tb_clic_irq_dispatch;

    localparam int NumSrc      = 256;
    localparam int SrcPerCycle = 16;
    localparam int LevelWidth  = 8;
    localparam int IdWidth     = 8;
    localparam int NumGrp      = NumSrc / SrcPerCycle;

    logic                         clk_i = 1'b0;
    logic                         rst_ni = 1'b0;
    logic                         enable_i;
    logic [NumSrc-1:0]            ip_i, ie_i, shv_i, edge_i;
    logic [NumSrc*LevelWidth-1:0] level_i;
    logic [2*NumSrc-1:0]          priv_i;
    logic [LevelWidth-1:0]        thresh_i;
    logic                         irq_valid_o;
    logic                         irq_ready_i = 1'b0;
    logic [IdWidth-1:0]           irq_id_o;
    logic [LevelWidth-1:0]        irq_level_o;
    logic [1:0]                   irq_priv_o;
    logic                         irq_shv_o;
    logic                         irq_kill_req_o;
    logic                         irq_kill_ack_i = 1'b0;
    logic                         ip_clr_valid_o;
    logic [IdWidth-1:0]           ip_clr_id_o;

    int checks   = 0;
    int failures = 0;

    clic_irq_dispatch #(
        .NumSrc(NumSrc), .SrcPerCycle(SrcPerCycle), .LevelWidth(LevelWidth)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
        .ip_i(ip_i), .ie_i(ie_i), .level_i(level_i), .priv_i(priv_i),
        .shv_i(shv_i), .edge_i(edge_i), .thresh_i(thresh_i),
        .irq_valid_o(irq_valid_o), .irq_ready_i(irq_ready_i),
        .irq_id_o(irq_id_o), .irq_level_o(irq_level_o), .irq_priv_o(irq_priv_o),
        .irq_shv_o(irq_shv_o), .irq_kill_req_o(irq_kill_req_o),
        .irq_kill_ack_i(irq_kill_ack_i), .ip_clr_valid_o(ip_clr_valid_o),
        .ip_clr_id_o(ip_clr_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        enable_i = 1'b0;
        ip_i = '0; ie_i = '0; shv_i = '0; edge_i = '0;
        level_i = '0; priv_i = '0; thresh_i = '0;
    endtask

    task automatic set_src(input int id, input int lvl, input int prv, input bit shv, input bit edg);
        ip_i[id] = 1'b1;
        ie_i[id] = 1'b1;
        level_i[id*LevelWidth +: LevelWidth] = LevelWidth'(lvl);
        priv_i[2*id +: 2] = 2'(prv);
        shv_i[id]  = shv;
        edge_i[id] = edg;
    endtask

    // One clock edge with reset low; returns at a falling edge with reset released.
    task automatic pulse_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_i);
            seen = irq_valid_o;
        end
    endtask

    task automatic wait_kill(input int budget, output bit seen, output int n);
        seen = 1'b0;
        n = 0;
        while (n < budget && !seen) begin
            @(negedge clk_i);
            n++;
            seen = irq_kill_req_o;
        end
    endtask

    // Reference: winner of the whole source array with the current stimulus.
    task automatic ref_best(output bit found, output int id);
        int best_key, key, lvl;
        best_key = -1;
        id = 0;
        for (int k = 0; k < NumSrc; k++) begin
            lvl = int'(level_i[k*LevelWidth +: LevelWidth]);
            if (enable_i && ip_i[k] && ie_i[k] && lvl > int'(thresh_i)) begin
                key = int'(priv_i[2*k +: 2]) * 65536 + lvl * 256 + k;
                if (key > best_key) begin
                    best_key = key;
                    id = k;
                end
            end
        end
        found = (best_key >= 0);
    endtask

    task automatic check_offer(input string tag, input int id);
        check({tag, "_id"},    32'(irq_id_o),    32'(id));
        check({tag, "_level"}, 32'(irq_level_o), 32'(level_i[id*LevelWidth +: LevelWidth]));
        check({tag, "_priv"},  32'(irq_priv_o),  32'(priv_i[2*id +: 2]));
        check({tag, "_shv"},   32'(irq_shv_o),   32'(shv_i[id]));
    endtask

    // Called at a falling edge with an offer up; the core takes it and drops the pending bit.
    task automatic accept_and_check(input int id, input bit exp_edge);
        irq_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        irq_ready_i = 1'b0;
        check("acc_valid_drop", 32'(irq_valid_o), 0);
        check("acc_clr_valid", 32'(ip_clr_valid_o), 32'(exp_edge));
        if (exp_edge) check("acc_clr_id", 32'(ip_clr_id_o), 32'(id));
        ip_i[id] = 1'b0;
        @(posedge clk_i);
        #1;
        check("acc_clr_pulse_end", 32'(ip_clr_valid_o), 0);
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({irq_valid_o, irq_kill_req_o, irq_id_o, irq_level_o, irq_priv_o,
                    irq_shv_o, ip_clr_valid_o, ip_clr_id_o});
    endfunction

    initial begin
        bit seen, found;
        int n, id, cnt;

        clear_inputs();
        repeat (2) @(negedge clk_i);
        check("reset_outputs", all_outputs(), 0);
        rst_ni = 1'b1;

        // Single level-triggered source.
        set_src(5, 8'h40, 3, 0, 0);
        enable_i = 1'b1;
        pulse_reset();
        wait_valid(NumGrp + 1, seen);
        check("single_seen", 32'(seen), 1);
        if (seen) begin
            check_offer("single", 5);
            accept_and_check(5, 1'b0);
        end

        // Id tie-break, then privilege dominance.
        clear_inputs();
        set_src(10, 8'h80, 3, 1, 0);
        set_src(200, 8'h80, 3, 0, 0);
        enable_i = 1'b1;
        pulse_reset();
        wait_valid(NumGrp + 1, seen);
        check("tie_seen", 32'(seen), 1);
        check_offer("tie", 200);
        priv_i[2*200 +: 2] = 2'd1;
        pulse_reset();
        wait_valid(NumGrp + 1, seen);
        check("priv_seen", 32'(seen), 1);
        check_offer("priv", 10);

        // Level must be strictly above the threshold.
        clear_inputs();
        set_src(9, 8'h20, 3, 0, 0);
        thresh_i = 8'h20;
        enable_i = 1'b1;
        pulse_reset();
        wait_valid(40, seen);
        check("thresh_equal_none", 32'(seen), 0);
        thresh_i = 8'h1F;
        wait_valid(2 * NumGrp + 1, seen);
        check("thresh_below_seen", 32'(seen), 1);
        check_offer("thresh", 9);

        // Preemption: a better source forces a kill one sweep after the offer.
        clear_inputs();
        set_src(3, 8'h10, 3, 0, 0);
        enable_i = 1'b1;
        pulse_reset();
        wait_valid(NumGrp + 1, seen);
        check("pre_seen", 32'(seen), 1);
        set_src(7, 8'h90, 3, 0, 0);
        wait_kill(40, seen, n);
        check("pre_kill_seen", 32'(seen), 1);
        check("pre_kill_cycles", 32'(n), 32'(NumGrp));
        check("pre_kill_valid", 32'(irq_valid_o), 1);
        check("pre_kill_id_stable", 32'(irq_id_o), 3);
        irq_kill_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        irq_kill_ack_i = 1'b0;
        check("pre_ack_drop", 32'({irq_valid_o, irq_kill_req_o}), 0);
        wait_valid(40, seen);
        check("pre_next_seen", 32'(seen), 1);
        check_offer("pre_next", 7);
        check("pre_next_no_kill", 32'(irq_kill_req_o), 0);

        // Ready in the cycle the kill condition resolves wins.
        clear_inputs();
        set_src(3, 8'h10, 3, 0, 1);
        enable_i = 1'b1;
        pulse_reset();
        wait_valid(NumGrp + 1, seen);
        check("rk_seen", 32'(seen), 1);
        set_src(7, 8'h90, 3, 0, 0);
        repeat (NumGrp - 1) @(negedge clk_i);
        irq_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        irq_ready_i = 1'b0;
        check("rk_accept", 32'({irq_valid_o, irq_kill_req_o, ip_clr_valid_o}), 1);
        check("rk_clr_id", 32'(ip_clr_id_o), 3);

        // Ready together with kill acknowledge wins.
        ip_i[7] = 1'b0;
        pulse_reset();
        wait_valid(NumGrp + 1, seen);
        check("ra_seen", 32'(seen), 1);
        set_src(7, 8'h90, 3, 0, 0);
        wait_kill(40, seen, n);
        check("ra_kill_seen", 32'(seen), 1);
        irq_ready_i = 1'b1;
        irq_kill_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        irq_ready_i = 1'b0;
        irq_kill_ack_i = 1'b0;
        check("ra_accept", 32'({irq_valid_o, irq_kill_req_o, ip_clr_valid_o}), 1);
        check("ra_clr_id", 32'(ip_clr_id_o), 3);

        // Edge source at the top id, then reset during an offer.
        clear_inputs();
        set_src(255, 8'h33, 3, 1, 1);
        enable_i = 1'b1;
        pulse_reset();
        wait_valid(NumGrp + 1, seen);
        check("edge_seen", 32'(seen), 1);
        check_offer("edge", 255);
        accept_and_check(255, 1'b1);
        ip_i[255] = 1'b1;
        wait_valid(40, seen);
        check("rst_offer_seen", 32'(seen), 1);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_mid_offer", all_outputs(), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Global disable kills an outstanding offer and blocks new ones.
        clear_inputs();
        set_src(5, 8'h40, 1, 0, 0);
        enable_i = 1'b1;
        pulse_reset();
        wait_valid(NumGrp + 1, seen);
        check("dis_seen", 32'(seen), 1);
        enable_i = 1'b0;
        wait_kill(2 * NumGrp + 1, seen, n);
        check("dis_kill_seen", 32'(seen), 1);
        irq_kill_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        irq_kill_ack_i = 1'b0;
        wait_valid(40, seen);
        check("dis_no_offer", 32'(seen), 0);

        // Randomized source sets, drained offer by offer.
        for (int r = 0; r < 12; r++) begin
            clear_inputs();
            thresh_i = LevelWidth'($urandom_range(0, 8'h40));
            cnt = $urandom_range(0, 6);
            for (int s = 0; s < cnt; s++) begin
                id = $urandom_range(0, NumSrc - 1);
                n = $urandom % 3;
                set_src(id, $urandom_range(0, 255), (n == 2) ? 3 : n, 1'($urandom), 1'($urandom));
                if ($urandom % 4 == 0) ie_i[id] = 1'b0;
            end
            ip_i[$urandom_range(0, NumSrc - 1)] = 1'b1;
            enable_i = ($urandom % 8 != 0);
            pulse_reset();
            for (int k = 0; k < 8; k++) begin
                ref_best(found, id);
                if (!found) begin
                    wait_valid(40, seen);
                    check("rnd_none", 32'(seen), 0);
                    break;
                end
                wait_valid(NumGrp + 1, seen);
                check("rnd_seen", 32'(seen), 1);
                if (!seen) break;
                check_offer("rnd", id);
                accept_and_check(id, edge_i[id]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
